// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file.
//   REGFILE_DATA_W : default register width
//   REGFILE_ADDR_W : default register index width
//   regIdx_t       : register index at default width
//   dataWord_t     : data word at default width
package reg_file_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;

    typedef logic [REGFILE_ADDR_W-1:0] regIdx_t;
    typedef logic [REGFILE_DATA_W-1:0] dataWord_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file.
// Ports:
//   regs      : stored register contents from the top level
//   readReg   : index to read
//   bypassEn  : a write is committing this cycle (index nonzero, not in reset)
//   writeReg  : index being written
//   writeData : data being written
//   readData  : selected data, with zero-register override and write-through
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic [DATA_W-1:0] regs [NREGS],
    input  logic [ADDR_W-1:0] readReg,
    input  logic              bypassEn,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] stored;

    always_comb begin
        stored = '0;
        // Equality decode rather than a direct index keeps an unknown or
        // out-of-range index from selecting anything but zero.
        for (int i = 0; i < NREGS; i++) begin
            if (readReg == ADDR_W'(i)) begin
                stored = regs[i];
            end
        end
        if (readReg == '0) begin
            stored = '0;
        end

        readData = stored;
        // bypassEn already excludes index 0 and reset, so no extra gating here.
        if (bypassEn && (readReg == writeReg)) begin
            readData = writeData;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with register 0 hardwired to zero and
// same-cycle write-through on both read ports.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high clear of all registers
//   ReadReg1/2 : read indices
//   WriteData  : write data
//   WriteReg   : write index
//   RegWrite   : write enable
//   ReadData1/2: combinational read data
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              writeEn;

    // Reset wins over a write, and writes to index 0 are dropped; the same
    // qualifier drives the bypass so reads never see a write that will not land.
    assign writeEn = RegWrite && !reset && (WriteReg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            for (int i = 1; i < NREGS; i++) begin
                if (WriteReg == ADDR_W'(i)) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) rdPort1 (
        .regs      (regs),
        .readReg   (ReadReg1),
        .bypassEn  (writeEn),
        .writeReg  (WriteReg),
        .writeData (WriteData),
        .readData  (ReadData1)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) rdPort2 (
        .regs      (regs),
        .readReg   (ReadReg2),
        .bypassEn  (writeEn),
        .writeReg  (WriteReg),
        .writeData (WriteData),
        .readData  (ReadData2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a vector table of directed cycles, an
// exhaustive write/read pass, and a random pass against a reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk;
    logic      reset;
    regIdx_t   ReadReg1, ReadReg2, WriteReg;
    dataWord_t WriteData;
    logic      RegWrite;
    dataWord_t ReadData1, ReadData2;

    reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteData (WriteData),
        .WriteReg  (WriteReg),
        .RegWrite  (RegWrite),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      rst;
        regIdx_t   r1;
        regIdx_t   r2;
        dataWord_t wd;
        regIdx_t   wr;
        logic      we;
        bit        chk;
        dataWord_t e1;
        dataWord_t e2;
        string     tag;
    } vec_t;

    typedef struct {
        dataWord_t e1;
        dataWord_t e2;
        string     tag;
    } exp_t;

    exp_t      sbq[$];
    dataWord_t mdl [32];
    int        total = 0;
    int        bad = 0;
    vec_t      vecs [14];

    // Expected read value from the reference model, before the edge.
    function automatic dataWord_t mexp(input logic rst, input regIdx_t r,
                                       input dataWord_t wd, input regIdx_t wr,
                                       input logic we);
        if (r == 0) return '0;
        if (!rst && we && wr != 0 && r == wr) return wd;
        return mdl[r];
    endfunction

    // Drive one cycle at the falling edge, check reads before the rising edge,
    // then advance the model across the rising edge.
    task automatic step(input logic rst, input regIdx_t r1, input regIdx_t r2,
                        input dataWord_t wd, input regIdx_t wr, input logic we,
                        input bit chk, input dataWord_t e1, input dataWord_t e2,
                        input string tag);
        exp_t ex;
        @(negedge clk);
        reset     = rst;
        ReadReg1  = r1;
        ReadReg2  = r2;
        WriteData = wd;
        WriteReg  = wr;
        RegWrite  = we;
        if (chk) begin
            ex.e1 = e1;
            ex.e2 = e2;
            ex.tag = tag;
            sbq.push_back(ex);
        end
        #2;
        if (sbq.size() > 0) begin
            ex = sbq.pop_front();
            total++;
            if (ReadData1 !== ex.e1) begin
                bad++;
                $display("FAIL %s port1: got %h expected %h", ex.tag, ReadData1, ex.e1);
            end
            total++;
            if (ReadData2 !== ex.e2) begin
                bad++;
                $display("FAIL %s port2: got %h expected %h", ex.tag, ReadData2, ex.e2);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (we && wr != 0) begin
            mdl[wr] = wd;
        end
    endtask

    initial begin
        reset = 1'b1; ReadReg1 = '0; ReadReg2 = '0;
        WriteData = '0; WriteReg = '0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        //          rst r1 r2 wd            wr we chk e1            e2            tag
        vecs[0]  = '{1, 0, 3, 32'h0,        0, 0, 0, 32'h0,        32'h0,        "reset_edge"};
        vecs[1]  = '{0, 0, 3, 32'h0,        0, 0, 1, 32'h0,        32'h0,        "after_reset"};
        vecs[2]  = '{0, 1, 2, 32'h98635533, 2, 1, 1, 32'h0,        32'h98635533, "wr2_bypass"};
        vecs[3]  = '{0, 2, 2, 32'h0,        0, 0, 1, 32'h98635533, 32'h98635533, "rd2_both"};
        vecs[4]  = '{0, 0, 2, 32'h0,        0, 0, 1, 32'h0,        32'h98635533, "rd2_persist"};
        vecs[5]  = '{0, 0, 0, 32'hAFAFAFAF, 0, 1, 1, 32'h0,        32'h0,        "wr0_nobypass"};
        vecs[6]  = '{0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        "rd0_zero"};
        vecs[7]  = '{0, 7, 7, 32'h12345678, 7, 1, 1, 32'h12345678, 32'h12345678, "wr7_bypass"};
        vecs[8]  = '{0, 7, 2, 32'h0,        0, 0, 1, 32'h12345678, 32'h98635533, "rd7_rd2"};
        vecs[9]  = '{0, 7, 2, 32'h55555555, 7, 0, 1, 32'h12345678, 32'h98635533, "we0_hold"};
        vecs[10] = '{0, 7, 5, 32'h0,        0, 0, 1, 32'h12345678, 32'h0,        "rd7_after_hold"};
        vecs[11] = '{1, 5, 7, 32'hDEADBEEF, 5, 1, 1, 32'h0,        32'h12345678, "rst_no_bypass"};
        vecs[12] = '{0, 5, 7, 32'h0,        0, 0, 1, 32'h0,        32'h0,        "rst_priority"};
        vecs[13] = '{0, 2, 3, 32'h0,        0, 0, 1, 32'h0,        32'h0,        "rst_cleared"};

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].rst, vecs[v].r1, vecs[v].r2, vecs[v].wd, vecs[v].wr,
                 vecs[v].we, vecs[v].chk, vecs[v].e1, vecs[v].e2, vecs[v].tag);
        end

        // Exhaustive: fill 1..31 (plus an attempted write to 0), then read all.
        step(0, 0, 0, 32'hFFFFFFFF, 0, 1, 0, '0, '0, "fill0");
        for (int i = 1; i < 32; i++) begin
            step(0, 0, 0, 32'(i) * 32'h01010101, regIdx_t'(i), 1, 0, '0, '0, "fill");
        end
        for (int i = 0; i < 32; i++) begin
            step(0, regIdx_t'(i), regIdx_t'(31 - i), 32'h0, 0, 0, 1,
                 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101, "exhaustive");
        end

        // Random traffic against the model, with occasional reset.
        for (int n = 0; n < 300; n++) begin
            logic      rst;
            regIdx_t   r1, r2, wr;
            dataWord_t wd;
            logic      we;
            rst = ($urandom_range(0, 39) == 0);
            r1  = regIdx_t'($urandom_range(0, 31));
            r2  = (n % 5 == 0) ? r1 : regIdx_t'($urandom_range(0, 31));
            wr  = (n % 3 == 0) ? r1 : regIdx_t'($urandom_range(0, 31));
            wd  = $urandom;
            we  = ($urandom_range(0, 3) != 0);
            step(rst, r1, r2, wd, wr, we, 1,
                 mexp(rst, r1, wd, wr, we), mexp(rst, r2, wd, wr, we), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 32, register width.
- ADDR_W, 5, register index width.
- NREGS, 2**ADDR_W, register count.
REQ-002 Port `clk` SHALL be input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port `reset` SHALL be input, 1 bit, synchronous and active-high.
REQ-004 Port `ReadReg1` SHALL be input, ADDR_W bits, read port 1 index.
REQ-005 Port `ReadReg2` SHALL be input, ADDR_W bits, read port 2 index.
REQ-006 Port `WriteData` SHALL be input, DATA_W bits, write data.
REQ-007 Port `WriteReg` SHALL be input, ADDR_W bits, write index.
REQ-008 Port `RegWrite` SHALL be input, 1 bit, write enable, active-high.
REQ-009 Port `ReadData1` SHALL be output, DATA_W bits, read port 1 data.
REQ-010 Port `ReadData2` SHALL be output, DATA_W bits, read port 2 data.
REQ-011 Positional port order SHALL be: clk, reset, ReadReg1, ReadReg2, WriteData, WriteReg, RegWrite, ReadData1, ReadData2.

Function
REQ-012 Storage SHALL be NREGS registers of DATA_W bits each.
REQ-013 Reads SHALL be combinational: ReadDataN follows ReadRegN and the register contents with zero cycle latency.
REQ-014 Register 0 SHALL be hardwired zero: reads of index 0 return 0, and writes to index 0 are discarded.
REQ-015 Write: on a rising clk edge with reset=0, RegWrite=1 and WriteReg!=0, register[WriteReg] SHALL take WriteData.
REQ-016 With RegWrite=0, no register SHALL change.
REQ-017 Write-through bypass: while RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg, ReadDataN SHALL equal the current WriteData in the same cycle.
REQ-018 Both read ports SHALL be independent; both may address the same register, including the register being written, and both then return identical data.
REQ-019 Address wrap SHALL NOT occur; all ADDR_W-bit indices are valid.
REQ-020 X or Z on an unused read index SHALL NOT corrupt stored state.

Reset
REQ-021 When reset=1 at a rising clk edge, all registers SHALL clear to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; that write is lost.
REQ-023 Bypass SHALL be suppressed while reset=1; ReadDataN then reflects stored contents.
REQ-024 From the first edge after reset deassertion, and until the first write, all reads SHALL return 0.
REQ-025 Reset asserted mid-operation SHALL clear all written values at that edge.

Structure
REQ-026 DATA_W and ADDR_W defaults SHALL be defined in a shared package (reg_file_pkg) as constants, together with a register-index typedef and a data-word typedef.
REQ-027 One sub-module, reg_file_rd_port, SHALL be instantiated twice; it implements the index decode, the zero-register override and the bypass mux.
REQ-028 Storage and write logic SHALL reside in the top-level reg_file.

Verification
REQ-029 Reset then read: reset=1 for one edge, ReadReg1=0, ReadReg2=3 -> ReadData1=0, ReadData2=0.
REQ-030 Write then read: write 0x98635533 to reg 2, then ReadReg2=2 -> ReadData2=0x98635533 from the next cycle, persisting with RegWrite=0.
REQ-031 Zero register: write 0xAFAFAFAF to reg 0, then read reg 0 on both ports -> 0x00000000.
REQ-032 Bypass: RegWrite=1, WriteReg=7, WriteData=0x12345678, ReadReg1=7 in the same cycle -> ReadData1=0x12345678 before the edge, and reg 7 holds the value after the edge.
REQ-033 Reset priority: reset=1 and write 0xDEADBEEF to reg 5 on the same edge -> reg 5 reads 0 afterwards.
REQ-034 Exhaustive: write i*0x01010101 to regs 1..31, then read all regs on both ports -> each returns its written value, reg 0 returns 0.
